// File: rtl/tick_stopwatch_bcd_if.sv
// Control inputs and BCD display outputs of the tick-driven stopwatch.
// The controller (master) drives ticks and commands; the stopwatch (slave) returns digits and status.
interface tick_stopwatch_bcd_if;
  logic       tick;
  logic       start;
  logic       stop;
  logic       clr;
  logic       up;
  logic [3:0] d3;
  logic [3:0] d2;
  logic [3:0] d1;
  logic [3:0] d0;
  logic       running;
  logic       wrap;
  logic       dbg_state;

  // Inputs are plain level/pulse controls with no handshake: tick is a one-clk
  // enable and is consumed in the cycle it is high, with no back-pressure.
  modport master (
    output tick, start, stop, clr, up,
    input  d3, d2, d1, d0, running, wrap, dbg_state
  );

  modport slave (
    input  tick, start, stop, clr, up,
    output d3, d2, d1, d0, running, wrap, dbg_state
  );
endinterface

// File: rtl/tick_stopwatch_bcd.sv
// BCD stopwatch M:SS.T advanced by 0.1 s ticks, with start/stop, clear and up/down counting.
// All outputs are registered; dbg_state mirrors the FSM state register.
module tick_stopwatch_bcd #(
  parameter int unsigned MAX_MIN = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  tick_stopwatch_bcd_if.slave   bus
);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [3:0] MAX_D3 = 4'(MAX_MIN);

  state_e     state_q, state_d;
  logic [3:0] d3_q, d3_d;
  logic [3:0] d2_q, d2_d;
  logic [3:0] d1_q, d1_d;
  logic [3:0] d0_q, d0_d;
  logic       wrap_q, wrap_d;
  logic       count_en;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: if (bus.start && !bus.stop) state_d = ST_RUN;
      ST_RUN:  if (bus.stop)               state_d = ST_STOP;
      default: state_d = ST_STOP;
    endcase
  end

  // Only a tick seen while already in RUN counts, so the start cycle never counts.
  assign count_en = bus.tick && (state_q == ST_RUN);

  always_comb begin
    d3_d   = d3_q;
    d2_d   = d2_q;
    d1_d   = d1_q;
    d0_d   = d0_q;
    wrap_d = 1'b0;
    if (bus.clr) begin
      d3_d = 4'd0;
      d2_d = 4'd0;
      d1_d = 4'd0;
      d0_d = 4'd0;
    end else if (count_en) begin
      if (bus.up) begin
        if (d0_q != 4'd9) d0_d = d0_q + 4'd1;
        else begin
          d0_d = 4'd0;
          if (d1_q != 4'd9) d1_d = d1_q + 4'd1;
          else begin
            d1_d = 4'd0;
            if (d2_q != 4'd5) d2_d = d2_q + 4'd1;
            else begin
              d2_d = 4'd0;
              if (d3_q != MAX_D3) d3_d = d3_q + 4'd1;
              else begin
                d3_d   = 4'd0;
                wrap_d = 1'b1;
              end
            end
          end
        end
      end else begin
        if (d0_q != 4'd0) d0_d = d0_q - 4'd1;
        else begin
          d0_d = 4'd9;
          if (d1_q != 4'd0) d1_d = d1_q - 4'd1;
          else begin
            d1_d = 4'd9;
            if (d2_q != 4'd0) d2_d = d2_q - 4'd1;
            else begin
              d2_d = 4'd5;
              if (d3_q != 4'd0) d3_d = d3_q - 4'd1;
              else begin
                d3_d   = MAX_D3;
                wrap_d = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_STOP;
      d3_q    <= 4'd0;
      d2_q    <= 4'd0;
      d1_q    <= 4'd0;
      d0_q    <= 4'd0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d3_q    <= d3_d;
      d2_q    <= d2_d;
      d1_q    <= d1_d;
      d0_q    <= d0_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.d3        = d3_q;
  assign bus.d2        = d2_q;
  assign bus.d1        = d1_q;
  assign bus.d0        = d0_q;
  assign bus.wrap      = wrap_q;
  assign bus.running   = (state_q == ST_RUN);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_tick_stopwatch_bcd.sv
// Bench for tick_stopwatch_bcd: directed vector table plus hand-written long-count sequences.
module tb_tick_stopwatch_bcd;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   cnt;

  tick_stopwatch_bcd_if bus ();

  tick_stopwatch_bcd #(.MAX_MIN(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst_n;
    logic        tick;
    logic        start;
    logic        stop;
    logic        clr;
    logic        up;
    logic [15:0] exp_d;
    logic        exp_run;
    logic        exp_wrap;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {bus.d3, bus.d2, bus.d1, bus.d0};
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[3:0]   = 4'(n % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[11:8]  = 4'((n / 100) % 6);
    r[15:12] = 4'(n / 600);
    return r;
  endfunction

  // Drive one cycle of inputs, let the posedge pass, return sampled 1 ns later.
  task automatic apply(input logic r, input logic t, input logic sa, input logic so,
                       input logic c, input logic u);
    reset     = r;
    bus.tick  = t;
    bus.start = sa;
    bus.stop  = so;
    bus.clr   = c;
    bus.up    = u;
    @(posedge clk);
    #1;
    bus.tick  = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.clr   = 1'b0;
  endtask

  // Counted ticks in RUN, each checked against a decimal count model.
  task automatic run_ticks(input int n, input logic u);
    logic exp_wrap;
    for (int i = 0; i < n; i++) begin
      exp_wrap = 1'b0;
      if (u) begin
        if (cnt == 5999) begin cnt = 0; exp_wrap = 1'b1; end
        else cnt = cnt + 1;
      end else begin
        if (cnt == 0) begin cnt = 5999; exp_wrap = 1'b1; end
        else cnt = cnt - 1;
      end
      apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, u);
      check("tick_digits", digits(), to_bcd(cnt));
      check("tick_wrap", {15'd0, bus.wrap}, {15'd0, exp_wrap});
    end
  endtask

  task automatic restart();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cnt = 0;
    check("restart_digits", digits(), 16'h0000);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("restart_run", {15'd0, bus.running}, 16'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cnt   = 0;
    reset = 1'b0;
    bus.tick = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.clr = 1'b0; bus.up = 1'b1;

    //            rst  tick start stop clr up   digits    run  wrap
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h9599, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h9599, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h9599, 1'b1, 1'b1};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].rst_n, vecs[i].tick, vecs[i].start, vecs[i].stop, vecs[i].clr, vecs[i].up);
      check($sformatf("vec%0d_digits", i), digits(), vecs[i].exp_d);
      check($sformatf("vec%0d_run", i), {14'd0, bus.running, bus.dbg_state},
            {14'd0, vecs[i].exp_run, vecs[i].exp_run});
      check($sformatf("vec%0d_wrap", i), {15'd0, bus.wrap}, {15'd0, vecs[i].exp_wrap});
    end

    // Full up-count range with wrap, then down wrap.
    restart();
    run_ticks(10, 1'b1);
    check("seq_0_01_0", digits(), 16'h0010);
    run_ticks(589, 1'b1);
    check("seq_0_59_9", digits(), 16'h0599);
    run_ticks(1, 1'b1);
    check("seq_1_00_0", digits(), 16'h1000);
    run_ticks(5399, 1'b1);
    check("seq_9_59_9", digits(), 16'h9599);
    run_ticks(1, 1'b1);
    check("seq_wrap_up_digits", digits(), 16'h0000);
    check("seq_wrap_up_pulse", {15'd0, bus.wrap}, 16'd1);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("seq_wrap_one_clk", {15'd0, bus.wrap}, 16'd0);
    run_ticks(1, 1'b0);
    check("seq_wrap_down_digits", digits(), 16'h9599);
    check("seq_wrap_down_pulse", {15'd0, bus.wrap}, 16'd1);
    run_ticks(1, 1'b0);
    check("seq_9_59_8", digits(), 16'h9598);

    // Start and stop together while running at 0:12.3.
    restart();
    run_ticks(123, 1'b1);
    check("seq_0_12_3", digits(), 16'h0123);
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("seq_startstop_run", {15'd0, bus.running}, 16'd0);
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("seq_stopped_hold", digits(), 16'h0123);

    // Clear beats a coincident tick at 0:05.7.
    restart();
    run_ticks(57, 1'b1);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cnt = 0;
    check("seq_clr_digits", digits(), 16'h0000);
    check("seq_clr_run", {14'd0, bus.running, bus.wrap}, 16'b10);
    run_ticks(1, 1'b1);
    check("seq_after_clr", digits(), 16'h0001);

    // Reset coincident with a tick at 0:33.3.
    restart();
    run_ticks(333, 1'b1);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("seq_rst_digits", digits(), 16'h0000);
    check("seq_rst_status", {14'd0, bus.running, bus.wrap}, 16'b00);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("seq_rst_no_start", digits(), 16'h0000);
    check("seq_rst_no_start_run", {15'd0, bus.running}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tick_stopwatch_bcd.md
Name: tick_stopwatch_bcd

Overview:
- Tick-driven BCD stopwatch, format M:SS.T (minutes, seconds tens, seconds units, tenths).
- Sits directly downstream of the mod-M binary tick counter. That counter's one-cycle max_tick, configured for a 0.1 s period, drives the tick input here.
- Provides start/stop control, clear, and up or down counting.
- Digit outputs feed the seven-segment display multiplexer.

Parameters:
- MAX_MIN, default 9: highest minutes value. Legal range 1..9. The counting range is 0:00.0 .. MAX_MIN:59.9.

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- reset  input  1  synchronous, active-low reset, sampled on posedge clk; reset=0 resets the block.
- tick  input  1  one-clk-wide enable pulse from the upstream mod-M counter's max_tick; one pulse = 0.1 s.
- start  input  1  pulse or level; requests RUN.
- stop  input  1  pulse or level; requests STOP.
- clr  input  1  synchronous clear of all digits.
- up  input  1  count direction: 1 = up, 0 = down; sampled on each counted tick.
- d3  output  4  minutes digit, 0..MAX_MIN.
- d2  output  4  seconds-tens digit, 0..5.
- d1  output  4  seconds-units digit, 0..9.
- d0  output  4  tenths digit, 0..9.
- running  output  1  1 while FSM is in RUN.
- wrap  output  1  one-clk pulse when the count wraps.

Behaviour:
- Reset (reset=0 at posedge clk):
  - FSM goes to STOP.
  - d3..d0 = 0; running = 0; wrap = 0.
  - Reset overrides all other inputs.
- FSM, two states, STOP and RUN:
  - STOP -> RUN when start=1 and stop=0.
  - RUN -> STOP when stop=1.
  - start=1 and stop=1 together: stop wins, next state is STOP.
  - Otherwise the FSM holds its state.
  - running is decoded from the state register, so it rises or falls one clk after the request edge.
- Counting:
  - A tick is counted only if tick=1 while the current state register = RUN. A tick in the same cycle as a start request is not counted.
  - The counted tick updates the digits at that same posedge, so digits change one clk after tick is sampled high.
  - All outputs are registered; there is no combinational path from inputs to outputs.
- Up (up=1):
  - d0 increments; 9 -> 0 carries into d1.
  - d1 9 -> 0 carries into d2.
  - d2 5 -> 0 carries into d3.
  - At MAX_MIN:59.9, the next counted tick gives 0:00.0 with wrap=1 for exactly one clk.
- Down (up=0):
  - d0 decrements; 0 -> 9 borrows from d1.
  - d1 0 -> 9 borrows from d2.
  - d2 0 -> 5 borrows from d3.
  - At 0:00.0, the next counted tick gives MAX_MIN:59.9 with wrap=1 for one clk.
- Direction change between ticks is legal and takes effect on the next counted tick.
- clr:
  - clr=1 sets d3..d0 to 0 next clk.
  - The FSM state is unchanged (the stopwatch keeps running from 0:00.0 if it was in RUN).
  - clr has priority over a coincident counted tick: that tick is dropped and wrap stays 0.
- Priority: reset > clr > counted tick > hold.
- Digits never leave their legal ranges. Each digit is a 4-bit register with explicit compare-to-limit, no binary overflow.
- tick held high for multiple clks counts once per clk. Upstream guarantees single-cycle pulses; this block does not edge-detect.
- wrap is 0 in every cycle that does not immediately follow a wrapping tick.
- Reset mid-count: all digits are 0 at the next clk and the FSM is in STOP. A tick arriving in that cycle is ignored.

Test Plan:
- Reset, then start pulse, then 10 ticks with up=1 -> running=1 one clk after start; digits 0:01.0; wrap never 1.
- Preload to 0:59.9 via 599 ticks, then one tick -> 1:00.0. With MAX_MIN=9, count to 9:59.9 and tick once -> 0:00.0 and wrap=1 for exactly one clk.
- From 0:00.0 with up=0 in RUN, one tick -> 9:59.9 and wrap=1; a second tick -> 9:59.8 and wrap=0.
- In RUN at 0:12.3, assert start and stop in the same cycle -> STOP next clk. Subsequent ticks leave 0:12.3 unchanged.
- In RUN at 0:05.7, assert clr and tick in the same cycle -> 0:00.0 and running stays 1. The next tick gives 0:00.1.
- At 0:33.3 in RUN, drive reset=0 coincident with tick -> 0:00.0, running=0, wrap=0. Release reset and tick without start -> digits unchanged.
